fetch_unit: RTL and testbench

- Front end of the pipeline.
- Holds the PC, issues in-order word requests on the instruction-memory bus, and pairs each returned encoding with its PC.
- Delivers `Uop::fetch_t` to decode through a valid/ready handshake.
- Consumes `Uop::redirect_pc_t` from the branch unit: discards everything fetched along the wrong path and restarts at the new PC.

---
 rtl/fetch_unit_pkg.sv | 26 ++
 rtl/fetch_queue.sv | 49 ++++
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - instruction and micro-op types shared by the fetch front end.
package Instr;
  typedef logic [31:0] enc_t;
endpackage

package Uop;
  typedef logic [29:0] iaddr_t;

  typedef struct packed {
    iaddr_t      pc;
    Instr::enc_t enc;
  } fetch_t;

  typedef struct packed {
    logic   valid;
    iaddr_t pc;
  } redirect_pc_t;

  typedef struct packed {
    logic   valid;
    iaddr_t addr;
  } imem_req_t;

  localparam int FETCH_DEPTH_MAX = 8;
  localparam int FETCH_CNT_W     = $clog2(FETCH_DEPTH_MAX + 1);
endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of arbitrary element type with flush and occupancy count.
module fetch_queue #(
  parameter type T     = logic,
  parameter int  DEPTH = 2,
  parameter int  CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  T                 pushData,
  input  logic             pop,
  output T                 head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  T mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= bump(wrPtr);
      if (pop) rdPtr <= bump(rdPtr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !(rst || flush)) mem[wrPtr] <= pushData;
  end

  assign head  = mem[rdPtr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC generation, credit-limited instruction fetch and wrong-path squashing.
module fetch_unit
  import Uop::*;
#(
  parameter iaddr_t RESET_PC = 30'h0,
  parameter int     DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  redirect_pc_t redirectIn,
  output logic         imemReqValid,
  input  logic         imemReqReady,
  output iaddr_t       imemReqAddr,
  input  logic         imemRespValid,
  input  Instr::enc_t  imemRespData,
  output logic         fetchValid,
  input  logic         fetchReady,
  output fetch_t       fetchOut
);
  localparam int CNT_W = FETCH_CNT_W;
  localparam logic [CNT_W:0] CAP = (CNT_W + 1)'(DEPTH);

  iaddr_t           reqPc;
  iaddr_t           respPc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] dropCnt;
  logic [CNT_W-1:0] queueCount;
  logic [CNT_W-1:0] nextOutstanding;
  logic [CNT_W:0]   credit;
  logic             redirect, reqFire, respFire, push, pop, qFull, qEmpty;
  imem_req_t        req;
  fetch_t           pushData;

  assign redirect = redirectIn.valid;

  // Credits cover both in-flight requests and queued entries, so pushes cannot overflow.
  assign credit       = {1'b0, outstanding} + {1'b0, queueCount};
  assign req          = '{valid: !rst && (credit < CAP), addr: reqPc};
  assign imemReqValid = req.valid;
  assign imemReqAddr  = req.addr;

  assign reqFire         = req.valid && imemReqReady;
  assign respFire        = imemRespValid;
  assign nextOutstanding = outstanding + CNT_W'(reqFire) - CNT_W'(respFire);

  assign push       = respFire && (dropCnt == '0) && !redirect;
  assign pushData   = '{pc: respPc, enc: imemRespData};
  assign fetchValid = !rst && !qEmpty && !redirect;
  assign pop        = fetchValid && fetchReady;

  always_ff @(posedge clk) begin
    if (rst) begin
      reqPc       <= RESET_PC;
      respPc      <= RESET_PC;
      outstanding <= '0;
      dropCnt     <= '0;
    end else begin
      outstanding <= nextOutstanding;
      if (redirect) begin
        // Everything still unanswered after this cycle belongs to the wrong path.
        reqPc   <= redirectIn.pc;
        respPc  <= redirectIn.pc;
        dropCnt <= nextOutstanding;
      end else begin
        if (reqFire) reqPc <= reqPc + 30'd1;
        if (respFire) begin
          if (dropCnt != '0) dropCnt <= dropCnt - CNT_W'(1);
          else respPc <= respPc + 30'd1;
        end
      end
    end
  end

  fetch_queue #(
    .T    (fetch_t),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) queue (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect),
    .push    (push),
    .pushData(pushData),
    .pop     (pop),
    .head    (fetchOut),
    .count   (queueCount),
    .full    (qFull),
    .empty   (qEmpty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(respFire && outstanding == '0));
      assert (!(push && qFull && !pop));
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized bench for fetch_unit against an in-order PC model.
module tb_fetch_unit;
  import Uop::*;

  localparam int     DEPTH  = 3;
  localparam iaddr_t RST_PC = 30'h100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  redirect_pc_t redirectIn;
  logic         imemReqValid;
  logic         imemReqReady;
  iaddr_t       imemReqAddr;
  logic         imemRespValid;
  Instr::enc_t  imemRespData;
  logic         fetchValid;
  logic         fetchReady;
  fetch_t       fetchOut;

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .redirectIn   (redirectIn),
    .imemReqValid (imemReqValid),
    .imemReqReady (imemReqReady),
    .imemReqAddr  (imemReqAddr),
    .imemRespValid(imemRespValid),
    .imemRespData (imemRespData),
    .fetchValid   (fetchValid),
    .fetchReady   (fetchReady),
    .fetchOut     (fetchOut)
  );

  int     tests = 0;
  int     fails = 0;
  int     cyc = 0;
  int     lat = 1;
  int     delivered = 0;
  int     reqFires = 0;
  int     base;
  int     n0;
  iaddr_t expReq, expFetch, firstPc, lastPc, lastReqAddr;
  logic   captureFirst = 1'b0;
  logic   sawWrap = 1'b0;
  logic   lastReqValid;
  iaddr_t pendAddr[$];
  int     pendDue[$];

  function automatic Instr::enc_t encOf(input iaddr_t a);
    return {a, 2'b01} ^ 32'hC0DE_5A5A ^ {2'b00, a[14:0], a[29:15]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, decide redirect, sample, advance the in-order model.
  task automatic step(input logic doRst, input logic doRedir, input iaddr_t tgt,
                      input logic rdy, input logic frdy, input logic redirOnBoth);
    logic respNow;
    logic redir;
    @(negedge clk);
    rst           = doRst;
    imemReqReady  = rdy;
    fetchReady    = frdy;
    respNow       = !doRst && pendAddr.size() > 0 && pendDue[0] <= cyc;
    imemRespValid = respNow;
    imemRespData  = respNow ? encOf(pendAddr[0]) : '0;
    redirectIn    = '{valid: 1'b0, pc: tgt};
    #1;
    redir = !doRst && (doRedir || (redirOnBoth && imemReqValid && rdy && respNow));
    redirectIn.valid = redir;
    #1;
    lastReqValid = imemReqValid;
    lastReqAddr  = imemReqAddr;
    if (doRst) begin
      chk("rst_reqValid", 64'(imemReqValid), 64'(0));
      chk("rst_fetchValid", 64'(fetchValid), 64'(0));
    end
    if (redir) chk("redir_fetchValid", 64'(fetchValid), 64'(0));
    if (imemReqValid && rdy) begin
      chk("req_addr", 64'(imemReqAddr), 64'(expReq));
      pendAddr.push_back(imemReqAddr);
      pendDue.push_back(cyc + lat);
      expReq = expReq + 30'd1;
      reqFires++;
    end
    if (respNow) begin
      void'(pendAddr.pop_front());
      void'(pendDue.pop_front());
    end
    if (fetchValid && frdy) begin
      chk("fetch_pc", 64'(fetchOut.pc), 64'(expFetch));
      chk("fetch_enc", 64'(fetchOut.enc), 64'(encOf(expFetch)));
      if (captureFirst) begin
        firstPc      = fetchOut.pc;
        captureFirst = 1'b0;
      end
      if (lastPc == 30'h3FFF_FFFF && fetchOut.pc == 30'h0) sawWrap = 1'b1;
      lastPc    = fetchOut.pc;
      expFetch  = expFetch + 30'd1;
      delivered++;
    end
    if (redir) begin
      expReq       = tgt;
      expFetch     = tgt;
      captureFirst = 1'b1;
    end
    if (doRst) begin
      pendAddr.delete();
      pendDue.delete();
      expReq   = RST_PC;
      expFetch = RST_PC;
    end
    chk("credit_bound", 64'(pendAddr.size() <= DEPTH), 64'(1));
    cyc++;
  endtask

  initial begin
    rst           = 1'b1;
    redirectIn    = '0;
    imemReqReady  = 1'b0;
    imemRespValid = 1'b0;
    imemRespData  = '0;
    fetchReady    = 1'b0;
    expReq        = RST_PC;
    expFetch      = RST_PC;
    firstPc       = '0;
    lastPc        = '0;

    // Reset release and sustained streaming with 1-cycle memory.
    repeat (3) step(1, 0, '0, 1, 1, 0);
    step(0, 0, '0, 1, 1, 0);
    chk("first_req_valid", 64'(lastReqValid), 64'(1));
    chk("first_req_addr", 64'(lastReqAddr), 64'(RST_PC));
    base = delivered;
    repeat (30) step(0, 0, '0, 1, 1, 0);
    chk("stream_rate", 64'(delivered - base >= 27), 64'(1));

    // Decode stalled: credits run out after DEPTH requests, then drain back to back.
    step(1, 0, '0, 1, 1, 0);
    n0 = reqFires;
    repeat (10) step(0, 0, '0, 1, 0, 0);
    chk("stall_reqs", 64'(reqFires - n0), 64'(DEPTH));
    chk("stall_reqValid", 64'(lastReqValid), 64'(0));
    chk("stall_fetchValid", 64'(fetchValid), 64'(1));
    base = delivered;
    step(0, 0, '0, 0, 1, 0);
    chk("credit_hold", 64'(lastReqValid), 64'(0));
    step(0, 0, '0, 0, 1, 0);
    chk("credit_resume", 64'(lastReqValid), 64'(1));
    step(0, 0, '0, 0, 1, 0);
    chk("drain_back_to_back", 64'(delivered - base), 64'(DEPTH));

    // Redirect with two requests in flight and one entry queued.
    step(1, 0, '0, 1, 1, 0);
    lat = 3;
    repeat (4) step(0, 0, '0, 1, 0, 0);
    step(0, 1, 30'h2000, 1, 1, 0);
    repeat (20) step(0, 0, '0, 1, 1, 0);
    chk("redir_first_pc", 64'(firstPc), 64'(30'h2000));

    // Redirect coinciding with a request handshake and a response; target near the wrap point.
    lat = 1;
    repeat (5) step(0, 0, '0, 1, 1, 0);
    captureFirst = 1'b0;
    for (int i = 0; i < 10 && !captureFirst; i++) step(0, 0, 30'h3FFF_FFFE, 1, 1, 1);
    chk("both_redir_seen", 64'(captureFirst), 64'(1));
    repeat (15) step(0, 0, '0, 1, 1, 0);
    chk("both_first_pc", 64'(firstPc), 64'(30'h3FFF_FFFE));
    chk("wrap_seen", 64'(sawWrap), 64'(1));

    // One-cycle reset with a full queue.
    repeat (8) step(0, 0, '0, 1, 0, 0);
    chk("full_fetchValid", 64'(fetchValid), 64'(1));
    step(1, 0, '0, 1, 1, 0);
    captureFirst = 1'b1;
    step(0, 0, '0, 1, 1, 0);
    chk("post_rst_req_valid", 64'(lastReqValid), 64'(1));
    chk("post_rst_req_addr", 64'(lastReqAddr), 64'(RST_PC));
    base = delivered;
    repeat (10) step(0, 0, '0, 1, 1, 0);
    chk("post_rst_first_pc", 64'(firstPc), 64'(RST_PC));
    chk("post_rst_delivers", 64'(delivered - base >= 5), 64'(1));

    // Randomized traffic: memory stalls, variable latency, decode stalls, redirects, resets.
    base = delivered;
    for (int i = 0; i < 1500; i++) begin
      logic   r;
      logic   d;
      iaddr_t t;
      if (i % 100 == 0) lat = $urandom_range(1, 4);
      r = ($urandom_range(0, 299) == 0);
      d = !r && ($urandom_range(0, 24) == 0);
      t = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFC : iaddr_t'($urandom);
      step(r, d, t, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'b0);
    end
    chk("random_liveness", 64'(delivered - base > 200), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
